// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: three 1-entry holds, round-robin grant, registered CDB.
// Build option: CDB_ALU_PRIO_EN gives the ALU hold absolute priority over LOAD/STORE.
module cdb_arbiter #(
    parameter int RB_W = 4,
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    input  logic            flush,
    input  logic            alu_valid,
    input  logic [XLEN-1:0] alu_val,
    input  logic [RB_W-1:0] alu_reorder,
    input  logic [XLEN-1:0] alu_targetPC,
    output logic            alu_ready,
    input  logic            ld_valid,
    input  logic [XLEN-1:0] ld_val,
    input  logic [RB_W-1:0] ld_reorder,
    output logic            ld_ready,
    input  logic            st_valid,
    input  logic [RB_W-1:0] st_reorder,
    output logic            st_ready,
    output logic            cdb_valid,
    output logic [1:0]      cdb_src,
    output logic [XLEN-1:0] cdb_val,
    output logic [RB_W-1:0] cdb_reorder,
    output logic [XLEN-1:0] cdb_targetPC
);

    typedef struct packed {
        logic [XLEN-1:0] val;
        logic [RB_W-1:0] tag;
        logic [XLEN-1:0] pc;
    } slot_t;

    slot_t      hold [3];
    slot_t      incoming [3];
    slot_t      win_slot;
    logic [2:0] full;
    logic [2:0] offer;
    logic [2:0] ready;
    logic [2:0] grant;
    logic [1:0] rr;
    logic [1:0] win;
    logic [1:0] next_rr;
    logic       win_ok;

    function automatic logic [1:0] inc3(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    always_comb begin
        incoming[0] = {alu_val, alu_reorder, alu_targetPC};
        incoming[1] = {ld_val, ld_reorder, {XLEN{1'b0}}};
        incoming[2] = {{XLEN{1'b0}}, st_reorder, {XLEN{1'b0}}};
    end

    assign offer = {st_valid, ld_valid, alu_valid};

`ifdef CDB_ALU_PRIO_EN
    logic [1:0] c0;
    logic [1:0] c1;

    // LOAD/STORE pointer lives in {1,2}; an rr of 0 starts the scan at LOAD.
    always_comb begin
        win    = 2'd0;
        win_ok = 1'b0;
        c0     = (rr == 2'd2) ? 2'd2 : 2'd1;
        c1     = (c0 == 2'd2) ? 2'd1 : 2'd2;
        if (full[0]) begin
            win    = 2'd0;
            win_ok = 1'b1;
        end else if (full[c0]) begin
            win    = c0;
            win_ok = 1'b1;
        end else if (full[c1]) begin
            win    = c1;
            win_ok = 1'b1;
        end
        next_rr = (win == 2'd0) ? rr : inc3(win);
    end
`else
    logic [1:0] c0;
    logic [1:0] c1;
    logic [1:0] c2;

    always_comb begin
        win    = 2'd0;
        win_ok = 1'b0;
        c0     = rr;
        c1     = inc3(c0);
        c2     = inc3(c1);
        if (full[c0]) begin
            win    = c0;
            win_ok = 1'b1;
        end else if (full[c1]) begin
            win    = c1;
            win_ok = 1'b1;
        end else if (full[c2]) begin
            win    = c2;
            win_ok = 1'b1;
        end
        next_rr = inc3(win);
    end
`endif

    always_comb begin
        case (win)
            2'd0:    win_slot = hold[0];
            2'd1:    win_slot = hold[1];
            default: win_slot = hold[2];
        endcase
    end

    assign grant = win_ok ? (3'b001 << win) : 3'b000;
    // A granted hold drains this edge, so it may take a new entry at once.
    assign ready = {3{rdy && !flush}} & (~full | grant);

    assign alu_ready = ready[0];
    assign ld_ready  = ready[1];
    assign st_ready  = ready[2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full         <= 3'b000;
            rr           <= 2'd0;
            cdb_valid    <= 1'b0;
            cdb_src      <= 2'd0;
            cdb_val      <= '0;
            cdb_reorder  <= '0;
            cdb_targetPC <= '0;
            for (int i = 0; i < 3; i++) begin
                hold[i] <= '0;
            end
        end else if (flush) begin
            full      <= 3'b000;
            cdb_valid <= 1'b0;
        end else if (rdy) begin
            for (int i = 0; i < 3; i++) begin
                if (offer[i] && ready[i]) begin
                    full[i] <= 1'b1;
                    hold[i] <= incoming[i];
                end else if (grant[i]) begin
                    full[i] <= 1'b0;
                end
            end
            cdb_valid <= win_ok;
            if (win_ok) begin
                cdb_src      <= win;
                cdb_val      <= win_slot.val;
                cdb_reorder  <= win_slot.tag;
                cdb_targetPC <= win_slot.pc;
                rr           <= next_rr;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter: directed vector table, hand sequences,
// and random traffic against a pending-slot reference model.
module tb_cdb_arbiter;

    localparam int RB_W = 4;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            rdy;
    logic            flush;
    logic            alu_valid;
    logic [XLEN-1:0] alu_val;
    logic [RB_W-1:0] alu_reorder;
    logic [XLEN-1:0] alu_targetPC;
    logic            alu_ready;
    logic            ld_valid;
    logic [XLEN-1:0] ld_val;
    logic [RB_W-1:0] ld_reorder;
    logic            ld_ready;
    logic            st_valid;
    logic [RB_W-1:0] st_reorder;
    logic            st_ready;
    logic            cdb_valid;
    logic [1:0]      cdb_src;
    logic [XLEN-1:0] cdb_val;
    logic [RB_W-1:0] cdb_reorder;
    logic [XLEN-1:0] cdb_targetPC;

    int checks = 0;
    int errors = 0;

    cdb_arbiter #(.RB_W(RB_W), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .alu_valid(alu_valid), .alu_val(alu_val),
        .alu_reorder(alu_reorder), .alu_targetPC(alu_targetPC),
        .alu_ready(alu_ready),
        .ld_valid(ld_valid), .ld_val(ld_val),
        .ld_reorder(ld_reorder), .ld_ready(ld_ready),
        .st_valid(st_valid), .st_reorder(st_reorder),
        .st_ready(st_ready),
        .cdb_valid(cdb_valid), .cdb_src(cdb_src), .cdb_val(cdb_val),
        .cdb_reorder(cdb_reorder), .cdb_targetPC(cdb_targetPC)
    );

    always #5 clk = ~clk;

    // Reference model: one pending slot per source, rr pointer, expected bus.
    bit              pend [3];
    logic [XLEN-1:0] pv [3];
    logic [XLEN-1:0] pp [3];
    logic [RB_W-1:0] pt [3];
    int              rr_m;
    logic            m_valid;
    logic [1:0]      m_src;
    logic [XLEN-1:0] m_val;
    logic [RB_W-1:0] m_tag;
    logic [XLEN-1:0] m_pc;

    task automatic chk(input string n, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", n, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) pend[i] = 0;
        rr_m = 0;
        m_valid = 0; m_src = 0; m_val = 0; m_tag = 0; m_pc = 0;
    endtask

    function automatic int m_grant();
`ifdef CDB_ALU_PRIO_EN
        int start;
        if (pend[0]) return 0;
        start = (rr_m == 2) ? 2 : 1;
        for (int k = 0; k < 2; k++) begin
            int s = 1 + ((start - 1 + k) % 2);
            if (pend[s]) return s;
        end
        return -1;
`else
        for (int k = 0; k < 3; k++) begin
            if (pend[(rr_m + k) % 3]) return (rr_m + k) % 3;
        end
        return -1;
`endif
    endfunction

    function automatic bit m_ready(input int x);
        return rdy && !flush && (!pend[x] || m_grant() == x);
    endfunction

    function automatic bit in_valid(input int x);
        return (x == 0) ? alu_valid : (x == 1) ? ld_valid : st_valid;
    endfunction

    task automatic model_edge();
        int g;
        bit acc [3];
        g = m_grant();
        for (int x = 0; x < 3; x++) acc[x] = in_valid(x) && m_ready(x);
        if (flush) begin
            for (int x = 0; x < 3; x++) pend[x] = 0;
            m_valid = 0;
        end else if (rdy) begin
            if (g >= 0) begin
                m_valid = 1;
                m_src = 2'(g);
                m_val = pv[g];
                m_tag = pt[g];
                m_pc = pp[g];
                pend[g] = 0;
`ifdef CDB_ALU_PRIO_EN
                if (g != 0) rr_m = (g + 1) % 3;
`else
                rr_m = (g + 1) % 3;
`endif
            end else begin
                m_valid = 0;
            end
            if (acc[0]) begin
                pend[0] = 1; pv[0] = alu_val;
                pt[0] = alu_reorder; pp[0] = alu_targetPC;
            end
            if (acc[1]) begin
                pend[1] = 1; pv[1] = ld_val;
                pt[1] = ld_reorder; pp[1] = '0;
            end
            if (acc[2]) begin
                pend[2] = 1; pv[2] = '0;
                pt[2] = st_reorder; pp[2] = '0;
            end
        end
    endtask

    task automatic drive(input bit r, input bit f,
                         input bit av, input logic [RB_W-1:0] at,
                         input logic [XLEN-1:0] aval,
                         input logic [XLEN-1:0] apc,
                         input bit lv, input logic [RB_W-1:0] lt,
                         input logic [XLEN-1:0] lval,
                         input bit sv, input logic [RB_W-1:0] stg);
        rdy = r; flush = f;
        alu_valid = av; alu_reorder = at;
        alu_val = aval; alu_targetPC = apc;
        ld_valid = lv; ld_reorder = lt; ld_val = lval;
        st_valid = sv; st_reorder = stg;
    endtask

    task automatic check_outputs();
        chk("cdb_valid", 32'(cdb_valid), 32'(m_valid));
        chk("cdb_src", 32'(cdb_src), 32'(m_src));
        chk("cdb_val", cdb_val, m_val);
        chk("cdb_reorder", 32'(cdb_reorder), 32'(m_tag));
        chk("cdb_targetPC", cdb_targetPC, m_pc);
    endtask

    // Called at posedge+1 with inputs already driven.
    task automatic tick(output logic [2:0] rmask);
        #2;
        rmask = {st_ready, ld_ready, alu_ready};
        chk("alu_ready", 32'(alu_ready), 32'(m_ready(0)));
        chk("ld_ready", 32'(ld_ready), 32'(m_ready(1)));
        chk("st_ready", 32'(st_ready), 32'(m_ready(2)));
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    typedef struct packed {
        logic       r, f, av, lv, sv;
        logic [3:0] at, lt, st;
        logic [2:0] er;
        logic       ev;
        logic [1:0] es;
        logic [3:0] et;
    } vec_t;

    function automatic vec_t mk(int r, int f, int av, int lv, int sv,
                                int at, int lt, int st,
                                int er, int ev, int es, int et);
        vec_t v;
        v.r = 1'(r); v.f = 1'(f);
        v.av = 1'(av); v.lv = 1'(lv); v.sv = 1'(sv);
        v.at = 4'(at); v.lt = 4'(lt); v.st = 4'(st);
        v.er = 3'(er); v.ev = 1'(ev); v.es = 2'(es); v.et = 4'(et);
        return v;
    endfunction

    vec_t tbl [14];

    initial begin
        logic [2:0] rm;
        int cnt [3];

        tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0);
        tbl[1]  = mk(1, 0, 1, 1, 1, 1, 2, 3, 7, 0, 0, 0);
        tbl[2]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1);
        tbl[3]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 3, 1, 1, 2);
        tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2);
        tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2);
        tbl[6]  = mk(1, 0, 0, 0, 1, 0, 0, 9, 7, 1, 2, 3);
        tbl[7]  = mk(1, 1, 0, 1, 0, 0, 7, 0, 0, 0, 0, 0);
        tbl[8]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0);
        tbl[9]  = mk(1, 0, 1, 1, 0, 5, 4, 0, 7, 0, 0, 0);
        tbl[10] = mk(1, 0, 1, 0, 0, 6, 0, 0, 5, 1, 0, 5);
        tbl[11] = mk(1, 0, 0, 0, 0, 0, 0, 0, 6, 1, 1, 4);
        tbl[12] = mk(1, 0, 0, 0, 0, 0, 0, 0, 7, 1, 0, 6);
        tbl[13] = mk(1, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0);

        rst = 1'b0;
        model_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        check_outputs();
        #10;
        rst = 1'b1;
        @(posedge clk);
        #1;

`ifndef CDB_ALU_PRIO_EN
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].r, tbl[i].f,
                  tbl[i].av, tbl[i].at, 32'h100 + 32'(tbl[i].at),
                  32'h1000 + 32'(tbl[i].at),
                  tbl[i].lv, tbl[i].lt, 32'h200 + 32'(tbl[i].lt),
                  tbl[i].sv, tbl[i].st);
            tick(rm);
            chk($sformatf("vec%0d_ready", i), 32'(rm), 32'(tbl[i].er));
            chk($sformatf("vec%0d_valid", i), 32'(cdb_valid), 32'(tbl[i].ev));
            if (tbl[i].ev) begin
                chk($sformatf("vec%0d_src", i), 32'(cdb_src), 32'(tbl[i].es));
                chk($sformatf("vec%0d_tag", i), 32'(cdb_reorder), 32'(tbl[i].et));
            end
        end
`endif

        // Single ALU result: broadcast one edge after acceptance.
        drive(1, 0, 1, 3, 32'h5, 32'h100, 0, 0, 0, 0, 0);
        tick(rm);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(rm);
        chk("alu1_valid", 32'(cdb_valid), 1);
        chk("alu1_src", 32'(cdb_src), 0);
        chk("alu1_val", cdb_val, 32'h5);
        chk("alu1_tag", 32'(cdb_reorder), 3);
        chk("alu1_pc", cdb_targetPC, 32'h100);
        tick(rm);
        chk("alu1_pulse", 32'(cdb_valid), 0);

        // All three sources valid continuously.
        for (int i = 0; i < 3; i++) cnt[i] = 0;
        for (int c = 0; c < 10; c++) begin
            drive(1, 0, 1, 4'(c), 32'(c), 32'(c), 1, 4'(c), 32'(c), 1, 4'(c));
            tick(rm);
            if (cdb_valid) cnt[cdb_src]++;
        end
`ifdef CDB_ALU_PRIO_EN
        chk("prio_alu_grants", 32'(cnt[0]), 9);
        chk("prio_ld_grants", 32'(cnt[1]), 0);
`else
        chk("rr_alu_grants", 32'(cnt[0]), 3);
        chk("rr_ld_grants", 32'(cnt[1]), 3);
        chk("rr_st_grants", 32'(cnt[2]), 3);
`endif
        for (int c = 0; c < 4; c++) begin
            drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            tick(rm);
        end

        // Async reset while a load is pending.
        drive(1, 0, 0, 0, 0, 0, 1, 4'd7, 32'hdead, 0, 0);
        tick(rm);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        check_outputs();
        #2;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick(rm);
            chk("post_rst_idle", 32'(cdb_valid), 0);
        end

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            drive($urandom_range(9) != 0, $urandom_range(19) == 0,
                  1'($urandom), 4'($urandom), $urandom, $urandom,
                  1'($urandom), 4'($urandom), $urandom,
                  1'($urandom), 4'($urandom));
            tick(rm);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
